button_press_decoder: RTL and testbench
=======================================

Name: button_press_decoder

Overview:
Sits directly upstream of the stopwatch controller and replaces the single-pulse button path. It takes the raw mechanical button and produces one-cycle command strobes. The block synchronises and debounces the input, then classifies each press:
- short press → short_pulse (start/stop)
- long press → long_pulse (clear)
All timing runs on the 100 MHz system clock. Simulation builds use shortened counts.

Parameters:
sim, 0, 1 selects the simulation counts below; 0 selects the hardware counts.
debounce_n, 1000000, stable cycles required to accept a level change (10 ms); forced to 4 when sim=1.
debounce_bits, 20, debounce counter width; forced to 3 when sim=1.
long_n, 100000000, cycles from debounced press to long classification (1 s); forced to 16 when sim=1.
long_bits, 27, hold counter width; forced to 5 when sim=1.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; clears all state immediately
button_in  input  1  raw, unsynchronised, bouncy button level (1 = pressed)
pressed  output  1  debounced button level, registered
short_pulse  output  1  one-cycle strobe: press released before long_n
long_pulse  output  1  one-cycle strobe: press held for long_n cycles

Behaviour:
- Reset (reset=0) state:
  - sync flops = 0, stable level = 0, both counters = 0, FSM = IDLE.
  - pressed = 0, short_pulse = 0, long_pulse = 0.
  - All of these hold while reset is low.
- Synchroniser: two flops on button_in, giving 2 cycles of latency.
- Debounce filter:
  - Counter increments on each cycle where the synced level differs from the stable level. It clears to 0 on any cycle where they match.
  - When the counter reaches debounce_n-1 with a mismatch still present, stable takes the synced value and the counter clears.
  - Net latency from a clean button_in edge to the pressed edge is debounce_n+2 cycles.
  - Any pulse shorter than debounce_n cycles after synchronisation is discarded.
- pressed is the stable level.
- FSM states:
  - IDLE: on pressed rising, go to HELD and clear the hold counter.
  - HELD:
    - Hold counter increments every cycle.
    - If pressed falls, short_pulse = 1 for the next cycle only, then go to IDLE.
    - If the counter reaches long_n-1 while pressed = 1, long_pulse = 1 for the next cycle only, then go to LONG_HELD.
    - If pressed falls on the same cycle the counter reaches long_n-1, the release wins: short pulse only.
  - LONG_HELD: wait for pressed falling, then go to IDLE. No strobe on this release.
- Pulse timing:
  - long_pulse asserts exactly long_n cycles after pressed rises.
  - short_pulse asserts the cycle after pressed falls.
- Mutual exclusion:
  - short_pulse and long_pulse are never high together.
  - Neither is high for more than one consecutive cycle.
  - At most one strobe per press.
- Hold counter saturation: the counter does not advance in IDLE or LONG_HELD, so it cannot wrap.
- Reset mid-operation: state clears with no strobe generated.
- Button held through reset release:
  - Synced level becomes 1 while stable = 0.
  - This is debounced and treated as a fresh press: pressed rises debounce_n+2 cycles after reset release.

Decomposition:
- Shared package (stopwatch_pkg):
  - FSM state encoding: IDLE=2'd0, HELD=2'd1, LONG_HELD=2'd2.
  - Hardware/simulation count constants (debounce 1000000/4, long 100000000/16), so the top level and this block select them identically from sim.
- One natural sub-module: debounce_filter, containing the synchroniser plus debounce counter. It has parameters debounce_n and debounce_bits, and ports clk, reset, din, dout.
- The FSM and hold counter stay in button_press_decoder.

Test Plan (sim=1: debounce_n=4, long_n=16):
1. Reset: assert reset=0 with button_in toggling → pressed, short_pulse, long_pulse all 0 throughout; after release with button_in=0, all outputs stay 0.
2. Glitch rejection: button_in high 3 cycles then low → pressed never rises; no strobes.
3. Short press: button_in high 12 cycles →
   - pressed rises 6 cycles after the button_in rise and falls 6 cycles after the button_in fall.
   - short_pulse high exactly 1 cycle, the cycle after pressed falls.
   - long_pulse stays 0.
4. Long press: button_in high 40 cycles →
   - long_pulse high 1 cycle, exactly 16 cycles after pressed rises.
   - No short_pulse on release.
   - FSM back in IDLE after pressed falls.
5. Bounce: button_in toggles every 2 cycles for 20 cycles, then steady high 10 cycles, then low →
   - exactly one pressed high interval;
   - exactly one short_pulse.
6. Reset mid-press: assert reset while in HELD with button_in still high →
   - outputs 0 immediately, no strobe;
   - after reset release, pressed rises 6 cycles later;
   - releasing the button yields one short_pulse.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and count constants for the stopwatch front end.
// Top level and button decoder select debounce/hold counts from `sim` identically.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_HELD = 2'd2
  } state_e;

  localparam int unsigned DEBOUNCE_N_HW    = 1000000;
  localparam int unsigned DEBOUNCE_N_SIM   = 4;
  localparam int unsigned DEBOUNCE_BITS_HW  = 20;
  localparam int unsigned DEBOUNCE_BITS_SIM = 3;
  localparam int unsigned LONG_N_HW        = 100000000;
  localparam int unsigned LONG_N_SIM       = 16;
  localparam int unsigned LONG_BITS_HW     = 27;
  localparam int unsigned LONG_BITS_SIM    = 5;

  function automatic int unsigned pick_count(input bit sim, input int unsigned hw,
                                             input int unsigned sim_val);
    return sim ? sim_val : hw;
  endfunction

endpackage

// File: rtl/button_press_decoder_if.sv
// Button decoder signal bundle: raw button in, debounced level and command strobes out.
// state is a debug view of the press classifier FSM.
interface button_press_decoder_if;
  import stopwatch_pkg::*;

  // No handshake: button_in is a free-running level; short_pulse/long_pulse are
  // single-cycle strobes with no back-pressure, the consumer must sample every cycle.
  logic   button_in;
  logic   pressed;
  logic   short_pulse;
  logic   long_pulse;
  state_e state;

  modport master (output button_in, input pressed, short_pulse, long_pulse, state);
  modport slave  (input button_in, output pressed, short_pulse, long_pulse, state);
endinterface

// File: rtl/button_press_decoder_debounce_filter.sv
// Two-flop synchroniser followed by a stability counter; dout only changes after
// the synchronised level has disagreed with it for debounce_n consecutive cycles.
module debounce_filter #(
  parameter int unsigned debounce_n    = 4,
  parameter int unsigned debounce_bits = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic                     sync1_q, sync1_d;
  logic                     sync2_q, sync2_d;
  logic                     stable_q, stable_d;
  logic [debounce_bits-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = din;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // Any cycle of agreement restarts the count, so bounces never accumulate.
    if (sync2_q != stable_q) begin
      if (cnt_q == debounce_bits'(debounce_n - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/button_press_decoder.sv
// Debounces the raw button and classifies each press into a one-cycle short
// (start/stop) or long (clear) command strobe.
module button_press_decoder
  import stopwatch_pkg::*;
#(
  parameter bit sim = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  button_press_decoder_if.slave bus
);

  localparam int unsigned debounce_n    = pick_count(sim, DEBOUNCE_N_HW, DEBOUNCE_N_SIM);
  localparam int unsigned debounce_bits = pick_count(sim, DEBOUNCE_BITS_HW, DEBOUNCE_BITS_SIM);
  localparam int unsigned long_n        = pick_count(sim, LONG_N_HW, LONG_N_SIM);
  localparam int unsigned long_bits     = pick_count(sim, LONG_BITS_HW, LONG_BITS_SIM);

  logic                 pressed_w;
  state_e               state_q, state_d;
  logic [long_bits-1:0] hold_cnt_q, hold_cnt_d;
  logic                 short_q, short_d;
  logic                 long_q, long_d;

  debounce_filter #(
    .debounce_n    (debounce_n),
    .debounce_bits (debounce_bits)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (bus.button_in),
    .dout  (pressed_w)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    short_d    = 1'b0;
    long_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed_w) begin
          state_d    = HELD;
          hold_cnt_d = '0;
        end
      end
      HELD: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        // Release is checked first so a release on the threshold cycle stays short.
        if (!pressed_w) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else if (hold_cnt_d == long_bits'(long_n - 1)) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (!pressed_w) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      short_q    <= short_d;
      long_q     <= long_d;
    end
  end

  assign bus.pressed     = pressed_w;
  assign bus.short_pulse = short_q;
  assign bus.long_pulse  = long_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench for button_press_decoder (sim counts: debounce 4, long 16).
// Expected pressed edges and strobes are queued with their cycle stamps.
module tb_button_press_decoder;
  import stopwatch_pkg::*;

  localparam logic [1:0] EV_RISE  = 2'd0;
  localparam logic [1:0] EV_FALL  = 2'd1;
  localparam logic [1:0] EV_SHORT = 2'd2;
  localparam logic [1:0] EV_LONG  = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_press_decoder_if bus ();

  button_press_decoder #(.sim(1'b1)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic expect_ev(input logic [1:0] kind, input int c);
    exp_q.push_back({kind, 30'(c)});
  endtask

  task automatic check_event(input logic [1:0] kind);
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got kind=%0d at cyc=%0d, required none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e[31:30] != kind || int'(e[29:0]) != cyc) begin
        n_fail++;
        $display("FAIL event: got kind=%0d at cyc=%0d, required kind=%0d at cyc=%0d",
                 kind, cyc, e[31:30], e[29:0]);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // monitor
  logic prev_pressed = 1'b0;
  logic prev_short   = 1'b0;
  logic prev_long    = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      n_checks++;
      if (bus.pressed !== 1'b0 || bus.short_pulse !== 1'b0 || bus.long_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got p=%b s=%b l=%b, required 0 0 0",
                 bus.pressed, bus.short_pulse, bus.long_pulse);
      end
      prev_pressed = 1'b0;
      prev_short   = 1'b0;
      prev_long    = 1'b0;
    end else begin
      n_checks++;
      if ((bus.short_pulse && bus.long_pulse) || (bus.short_pulse && prev_short) ||
          (bus.long_pulse && prev_long)) begin
        n_fail++;
        $display("FAIL strobe_excl: got s=%b l=%b (prev s=%b l=%b) at cyc=%0d, required single isolated strobe",
                 bus.short_pulse, bus.long_pulse, prev_short, prev_long, cyc);
      end
      if (bus.pressed && !prev_pressed) check_event(EV_RISE);
      if (!bus.pressed && prev_pressed) check_event(EV_FALL);
      if (bus.short_pulse) check_event(EV_SHORT);
      if (bus.long_pulse) check_event(EV_LONG);
      prev_pressed = bus.pressed;
      prev_short   = bus.short_pulse;
      prev_long    = bus.long_pulse;
    end
  end

  // driver
  task automatic hold_level(input logic v, input int n);
    bus.button_in = v;
    repeat (n) @(negedge clk);
  endtask

  int t, r;

  initial begin
    rst_n = 1'b0;
    bus.button_in = 1'b0;
    @(negedge clk);

    // 1: reset held with a toggling button
    for (int i = 0; i < 10; i++) begin
      bus.button_in = ~bus.button_in;
      @(negedge clk);
    end
    bus.button_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold_level(1'b0, 12);
    check_bit("idle_pressed", bus.pressed, 1'b0);
    check_bit("idle_state", bus.state == IDLE, 1'b1);

    // 2: glitch of 3 cycles is rejected
    hold_level(1'b1, 3);
    hold_level(1'b0, 12);
    check_bit("glitch_pressed", bus.pressed, 1'b0);

    // 3: short press of 12 cycles
    t = cyc;
    expect_ev(EV_RISE, t + 6);
    expect_ev(EV_FALL, t + 18);
    expect_ev(EV_SHORT, t + 19);
    hold_level(1'b1, 12);
    hold_level(1'b0, 14);

    // 4: long press of 40 cycles
    t = cyc;
    expect_ev(EV_RISE, t + 6);
    expect_ev(EV_LONG, t + 22);
    expect_ev(EV_FALL, t + 46);
    hold_level(1'b1, 40);
    hold_level(1'b0, 12);
    check_bit("long_back_idle", bus.state == IDLE, 1'b1);

    // 5: bounce then steady 10-cycle press
    t = cyc;
    expect_ev(EV_RISE, t + 26);
    expect_ev(EV_FALL, t + 36);
    expect_ev(EV_SHORT, t + 37);
    for (int i = 0; i < 5; i++) begin
      hold_level(1'b1, 2);
      hold_level(1'b0, 2);
    end
    hold_level(1'b1, 10);
    hold_level(1'b0, 14);

    // 6: reset mid-press, button still held through release
    t = cyc;
    expect_ev(EV_RISE, t + 6);
    hold_level(1'b1, 10);
    check_bit("mid_state_held", bus.state == HELD, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("mid_reset_pressed", bus.pressed, 1'b0);
    check_bit("mid_reset_state", bus.state == IDLE, 1'b1);
    @(negedge clk);
    hold_level(1'b1, 3);
    rst_n = 1'b1;
    r = cyc;
    expect_ev(EV_RISE, r + 6);
    expect_ev(EV_FALL, r + 16);
    expect_ev(EV_SHORT, r + 17);
    hold_level(1'b1, 10);
    hold_level(1'b0, 14);

    // 7: 15-cycle press, release coincides with threshold -> short
    t = cyc;
    expect_ev(EV_RISE, t + 6);
    expect_ev(EV_FALL, t + 21);
    expect_ev(EV_SHORT, t + 22);
    hold_level(1'b1, 15);
    hold_level(1'b0, 14);

    // 8: 16-cycle press -> long, no short on release
    t = cyc;
    expect_ev(EV_RISE, t + 6);
    expect_ev(EV_FALL, t + 22);
    expect_ev(EV_LONG, t + 22);
    hold_level(1'b1, 16);
    hold_level(1'b0, 14);
    check_bit("boundary_idle", bus.state == IDLE, 1'b1);

    // report
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending events, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
